mem_access_stage: RTL and testbench

//  MEM stage of the pipelined CPU; sits between EX/MEM and MEM/WB buffers and drives MEM/WB inputs.
//  Non-memory ops pass through combinationally. Loads/stores run a variable-latency req/ack data-memory

---
 rtl/mem_access_stage_if.sv | 29 ++
 rtl/mem_access_stage.sv | 132 +++++++++++++
 tb/tb_mem_access_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/acknowledge bus used by the MEM stage
interface mem_access_stage_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [BIT_WIDTH-1:0] mem_addr;
  logic [BIT_WIDTH-1:0] mem_wdata;
  logic                 mem_ack;
  logic [BIT_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with variable-latency req/ack memory access
// Non-memory ops pass straight through; loads/stores stall the pipe until ack or timeout.
module mem_access_stage #(
  parameter int BIT_WIDTH           = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           is_load,
  input  logic                           is_store,
  input  logic                           reg_file_wrt_en_in,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_in,
  input  logic [BIT_WIDTH-1:0]           alu_res_in,
  input  logic [BIT_WIDTH-1:0]           store_data_in,
  mem_access_stage_if.master             mem,
  output logic                           stall,
  output logic                           reg_file_wrt_en_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] dst_ind_out,
  output logic [BIT_WIDTH-1:0]           end_res_out,
  output logic                           mem_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     wait_cnt;
  logic [BIT_WIDTH-1:0] rdata_q;
  logic                 mem_op;
  logic                 cnt_expired;

  assign mem_op      = in_valid & (is_load | is_store);
  assign cnt_expired = (wait_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // mem_timeout doubles as the "DONE because of abort" flag for the output mux.
  always_comb begin
    state_next          = state;
    stall               = 1'b0;
    reg_file_wrt_en_out = 1'b0;
    dst_ind_out         = '0;
    end_res_out         = '0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end else if (in_valid) begin
          reg_file_wrt_en_out = reg_file_wrt_en_in;
          dst_ind_out         = dst_ind_in;
          end_res_out         = alu_res_in;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem.mem_ack || cnt_expired) begin
          state_next = DONE;
        end
      end
      DONE: begin
        dst_ind_out = dst_ind_in;
        if (mem_timeout) begin
          end_res_out = '0;
        end else if (mem.mem_we) begin
          end_res_out = alu_res_in;
        end else begin
          reg_file_wrt_en_out = reg_file_wrt_en_in;
          end_res_out         = rdata_q;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      wait_cnt      <= '0;
      rdata_q       <= '0;
      mem_timeout   <= 1'b0;
    end else begin
      mem_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= {alu_res_in[BIT_WIDTH-1:2], 2'b00};
            mem.mem_wdata <= store_data_in;
            wait_cnt      <= '0;
          end
        end
        ACCESS: begin
          if (mem.mem_ack) begin
            rdata_q     <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
          end else if (cnt_expired) begin
            mem.mem_req <= 1'b0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        is_load;
  logic        is_store;
  logic        reg_file_wrt_en_in;
  logic [3:0]  dst_ind_in;
  logic [31:0] alu_res_in;
  logic [31:0] store_data_in;
  logic        stall;
  logic        reg_file_wrt_en_out;
  logic [3:0]  dst_ind_out;
  logic [31:0] end_res_out;
  logic        mem_timeout;

  mem_access_stage_if #(.BIT_WIDTH(32)) mbus ();

  mem_access_stage #(
    .BIT_WIDTH(32),
    .REG_INDEX_BIT_WIDTH(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .is_load            (is_load),
    .is_store           (is_store),
    .reg_file_wrt_en_in (reg_file_wrt_en_in),
    .dst_ind_in         (dst_ind_in),
    .alu_res_in         (alu_res_in),
    .store_data_in      (store_data_in),
    .mem                (mbus),
    .stall              (stall),
    .reg_file_wrt_en_out(reg_file_wrt_en_out),
    .dst_ind_out        (dst_ind_out),
    .end_res_out        (end_res_out),
    .mem_timeout        (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_model [0:63];

  typedef struct {
    logic        v, ld, st, wen;
    logic [3:0]  dst;
    logic [31:0] alu;
    logic        chk_data;
    logic        e_stall, e_wen;
    logic [3:0]  e_dst;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs [0:6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in IDLE and plays memory; expectations come from the memory model.
  task automatic run_op(input logic ld, input logic st, input logic wen, input logic [3:0] dst,
                        input logic [31:0] alu, input logic [31:0] sd, input int ack_at,
                        input bit gap, input string tag);
    logic        is_mem;
    bit          tmo;
    int          n;
    int          cyc;
    int          req_cnt;
    logic [5:0]  idx;
    logic        e_wen;
    logic [31:0] e_res;
    is_mem             = ld | st;
    idx                = alu[7:2];
    in_valid           = 1'b1;
    is_load            = ld;
    is_store           = st;
    reg_file_wrt_en_in = wen;
    dst_ind_in         = dst;
    alu_res_in         = alu;
    store_data_in      = sd;
    mbus.mem_ack       = 1'b0;
    if (!is_mem) begin
      #1;
      check({tag, " alu stall"}, 32'(stall), 32'd0);
      check({tag, " alu wen"}, 32'(reg_file_wrt_en_out), 32'(wen));
      check({tag, " alu dst"}, 32'(dst_ind_out), 32'(dst));
      check({tag, " alu res"}, end_res_out, alu);
      step();
    end else begin
      tmo = (ack_at < 1) || (ack_at > TMO);
      n   = tmo ? TMO : ack_at;
      if (tmo) begin
        e_wen = 1'b0; e_res = 32'd0;
      end else if (st) begin
        e_wen = 1'b0; e_res = alu;
      end else begin
        e_wen = wen;  e_res = mem_model[idx];
      end
      cyc     = 0;
      req_cnt = 0;
      while (1) begin
        mbus.mem_ack   = (cyc == ack_at);
        mbus.mem_rdata = (cyc == ack_at) ? mem_model[idx] : $urandom;
        #1;
        if (!stall || cyc >= 20) break;
        if (mbus.mem_req) req_cnt++;
        if (reg_file_wrt_en_out !== 1'b0) check({tag, " bubble wen"}, 32'(reg_file_wrt_en_out), 32'd0);
        if (cyc == 1) begin
          check({tag, " req"}, 32'(mbus.mem_req), 32'd1);
          check({tag, " we"}, 32'(mbus.mem_we), 32'(st));
          check({tag, " addr"}, mbus.mem_addr, alu & 32'hFFFF_FFFC);
          if (st) check({tag, " wdata"}, mbus.mem_wdata, sd);
        end
        step();
        cyc++;
      end
      check({tag, " stall cycles"}, 32'(cyc), 32'(n + 1));
      check({tag, " req cycles"}, 32'(req_cnt), 32'(n));
      check({tag, " done wen"}, 32'(reg_file_wrt_en_out), 32'(e_wen));
      check({tag, " done dst"}, 32'(dst_ind_out), 32'(dst));
      check({tag, " done res"}, end_res_out, e_res);
      check({tag, " done timeout"}, 32'(mem_timeout), 32'(tmo));
      check({tag, " done req"}, 32'(mbus.mem_req), 32'd0);
      if (!tmo && st) mem_model[idx] = sd;
      step();
      if (gap) begin
        in_valid     = 1'b0;
        mbus.mem_ack = 1'b1;
        #1;
        check({tag, " idle stall"}, 32'(stall), 32'd0);
        check({tag, " idle wen"}, 32'(reg_file_wrt_en_out), 32'd0);
        check({tag, " idle timeout"}, 32'(mem_timeout), 32'd0);
        step();
        check({tag, " late ack ignored"}, 32'(mbus.mem_req), 32'd0);
        mbus.mem_ack = 1'b0;
      end
    end
  endtask

  initial begin
    reset              = 1'b1;
    in_valid           = 1'b0;
    is_load            = 1'b0;
    is_store           = 1'b0;
    reg_file_wrt_en_in = 1'b0;
    dst_ind_in         = '0;
    alu_res_in         = '0;
    store_data_in      = '0;
    mbus.mem_ack       = 1'b0;
    mbus.mem_rdata     = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;

    vecs[0] = '{1, 0, 0, 1, 4'd3, 32'h15,        1, 0, 1, 4'd3, 32'h15};
    vecs[1] = '{0, 0, 0, 1, 4'd7, 32'h1234_5678, 1, 0, 0, 4'd0, 32'h0};
    vecs[2] = '{1, 0, 0, 0, 4'd9, 32'hCAFE_F00D, 1, 0, 0, 4'd9, 32'hCAFE_F00D};
    vecs[3] = '{1, 1, 0, 1, 4'd2, 32'h100,       0, 1, 0, 4'd0, 32'h0};
    vecs[4] = '{1, 0, 1, 1, 4'd5, 32'h200,       0, 1, 0, 4'd0, 32'h0};
    vecs[5] = '{1, 1, 1, 1, 4'd6, 32'h300,       0, 1, 0, 4'd0, 32'h0};
    vecs[6] = '{0, 1, 1, 1, 4'd8, 32'h400,       1, 0, 0, 4'd0, 32'h0};

    step();
    step();
    reset = 1'b0;
    #1;
    check("reset req", 32'(mbus.mem_req), 32'd0);
    check("reset we", 32'(mbus.mem_we), 32'd0);
    check("reset addr", mbus.mem_addr, 32'd0);
    check("reset wdata", mbus.mem_wdata, 32'd0);
    check("reset timeout", 32'(mem_timeout), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset wen", 32'(reg_file_wrt_en_out), 32'd0);

    foreach (vecs[i]) begin
      step();
      in_valid           = vecs[i].v;
      is_load            = vecs[i].ld;
      is_store           = vecs[i].st;
      reg_file_wrt_en_in = vecs[i].wen;
      dst_ind_in         = vecs[i].dst;
      alu_res_in         = vecs[i].alu;
      #1;
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d wen", i), 32'(reg_file_wrt_en_out), 32'(vecs[i].e_wen));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d dst", i), 32'(dst_ind_out), 32'(vecs[i].e_dst));
        check($sformatf("vec%0d res", i), end_res_out, vecs[i].e_res);
      end
      reset = 1'b1;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
    end
    step();

    // Directed scenarios.
    mem_model[0] = 32'hDEAD_BEEF;
    run_op(1, 0, 1, 4'd4, 32'h1003, 32'h0, 2, 1, "load_ack2");
    run_op(0, 1, 1, 4'd5, 32'h20, 32'h55, 1, 1, "store_ack1");
    run_op(1, 0, 1, 4'd6, 32'h44, 32'h0, -1, 1, "load_timeout");
    run_op(1, 1, 1, 4'd7, 32'h48, 32'h77, 3, 1, "ld_st_both");
    run_op(1, 0, 1, 4'd9, 32'h48, 32'h0, 4, 1, "load_after_store");

    // Reset during the second ACCESS cycle drops the op.
    in_valid           = 1'b1;
    is_load            = 1'b1;
    is_store           = 1'b0;
    reg_file_wrt_en_in = 1'b1;
    dst_ind_in         = 4'd11;
    alu_res_in         = 32'h80;
    mbus.mem_ack       = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid req", 32'(mbus.mem_req), 32'd0);
    check("rst_mid stall", 32'(stall), 32'd0);
    mbus.mem_ack   = 1'b1;
    mbus.mem_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_mid late req", 32'(mbus.mem_req), 32'd0);
      check("rst_mid late wen", 32'(reg_file_wrt_en_out), 32'd0);
      check("rst_mid late stall", 32'(stall), 32'd0);
    end
    mbus.mem_ack = 1'b0;
    step();

    // Back-to-back load, ALU op, store with no idle gap.
    run_op(1, 0, 1, 4'd1, 32'h0C, 32'h0, 2, 0, "b2b_load");
    run_op(0, 0, 1, 4'd2, 32'h1234, 32'h0, 0, 0, "b2b_alu");
    run_op(0, 1, 0, 4'd3, 32'h10, 32'hA5A5, 1, 1, "b2b_store");

    for (int r = 0; r < 60; r++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a    = $urandom;
      run_op(kind == 1 || kind == 3, kind >= 2, 1'($urandom), 4'($urandom), a, $urandom,
             $urandom_range(0, 6), 1'($urandom), $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
